serial_sub_nbits: RTL and testbench
===================================

Name: serial_sub_nbits

Overview:
- Multi-cycle bit-serial subtractor: the inverse of the ripple-carry adder. Computes diff = a - b - bin.
- Uses a single full-adder slice reused once per clock, LSB first. The slice adds a, ~b and ~bin; the complemented carry becomes the borrow.
- Start/done handshake, so a control FSM can issue area-cheap subtractions and collect the difference and borrow-out.

Parameters:
- WIDTH, 4, operand and result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse; diff and bout valid.
- diff  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, diff=0, bout=0. Internal operand registers, carry and counter cleared. Any in-flight operation is abandoned with no done pulse.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from the state register; nothing combinational from inputs.
- IDLE, start=1 at an edge:
  - Load A_r=a, B_r=~b, carry c=~bin, cnt=0; state->SHIFT.
  - diff and bout keep their previous values until overwritten.
- IDLE, start=0: remain in IDLE.
- SHIFT, each edge:
  - s = A_r[0]^B_r[0]^c.
  - c <= majority(A_r[0],B_r[0],c).
  - Result shift register takes s in at the MSB and shifts right. A_r and B_r shift right.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: diff <= final result, bout <= ~carry_out, state->DONE.
- DONE: done=1 for exactly one cycle; next edge -> IDLE.
- start is ignored in SHIFT and DONE; no queuing. start held high continuously yields back-to-back operations, with one IDLE cycle between done and the next accept.
- Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH. Throughput is one result per WIDTH+2 cycles.
- diff and bout hold after done until the next operation completes or reset.
- Inputs a, b and bin may change freely after the accepting edge without affecting the result.
- Counter width: enough bits to hold WIDTH-1. No wrap-around occurs because the counter is cleared on every accept.
- busy=1 exactly while state is SHIFT or DONE.

Test Plan:
- Reset: rst high 2 cycles with start=1 -> busy=0, done=0, diff=0, bout=0. No operation accepted while rst=1.
- WIDTH=4, a=9, b=3, bin=0, start pulse -> done after 5 cycles, diff=6, bout=0. busy high for 5 cycles.
- a=3, b=9, bin=0 -> diff=10 (4'b1010), bout=1. a=7, b=2, bin=1 -> diff=4, bout=0.
- Boundaries:
  - a=0, b=0, bin=1 -> diff=15, bout=1.
  - a=15, b=15, bin=0 -> diff=0, bout=0.
  - a=15, b=0, bin=0 -> diff=15, bout=0.
- Protocol:
  - Pulse start again mid-SHIFT with different operands -> ignored; the first result is delivered unchanged.
  - Change a, b and bin the cycle after accept -> result unaffected.
  - Hold start high -> one done per 6 cycles.
- Reset mid-operation: assert rst on cycle 2 of SHIFT -> no done pulse, outputs 0. A new start after reset completes correctly (a=12, b=5 -> diff=7, bout=0).

Source files
------------

// File: rtl/serial_sub_nbits.sv
// Bit-serial subtractor: one full-adder slice reused LSB first, computing
// diff = a - b - bin over WIDTH clocks behind a start/done handshake.
module serial_sub_nbits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Handshake: start is accepted only in IDLE; a, b and bin are captured on
  // that edge. done pulses for one cycle when diff/bout update; busy covers
  // SHIFT and DONE, during which start is ignored (no queuing).

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             s, c_next;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // b and bin are stored inverted so the slice is a plain adder; the final
  // carry is the complement of the borrow.
  assign s      = a_r[0] ^ b_r[0] ^ c;
  assign c_next = (a_r[0] & b_r[0]) | (a_r[0] & c) | (b_r[0] & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= ~b;
            c     <= ~bin;
            cnt   <= '0;
            res_r <= '0;
          end
        end
        SHIFT: begin
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          c     <= c_next;
          res_r <= {s, res_r[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff <= {s, res_r[WIDTH-1:1]};
            bout <= ~c_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_nbits.sv
// Directed bench for serial_sub_nbits (WIDTH=4): reset, arithmetic vectors,
// boundaries, handshake behaviour and reset during an operation.
module tb_serial_sub_nbits;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;

  serial_sub_nbits #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issues one start pulse, scrambles the operand inputs right after the
  // accepting edge, optionally pulses start again mid-SHIFT, then checks
  // latency, busy, result and the one-cycle done pulse.
  task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ibin, input logic [W-1:0] exp_diff, input logic exp_bout,
                        input bit glitch);
    int n;
    int busy_n;
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15)); bin = 1'($urandom_range(0, 1));
    n = 0; busy_n = 0;
    while (!done && n < 20) begin
      if (busy) busy_n++;
      if (glitch && n == 1) begin
        start = 1'b1; a = 4'd0; b = 4'd15; bin = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, W);
    check({tag, "_busy_shift"}, busy_n, W);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_diff"}, diff, exp_diff);
    check({tag, "_bout"}, bout, exp_bout);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_diff_hold"}, diff, exp_diff);
  endtask

  initial begin
    int cyc;
    int ndone;
    int done_at [3];

    rst = 1'b1; start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_no_accept", busy, 0);

    run_op("sub_9_3",    4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b0);
    run_op("sub_3_9",    4'd3,  4'd9,  1'b0, 4'd10, 1'b1, 1'b0);
    run_op("sub_7_2_b",  4'd7,  4'd2,  1'b1, 4'd4,  1'b0, 1'b0);
    run_op("sub_0_0_b",  4'd0,  4'd0,  1'b1, 4'd15, 1'b1, 1'b0);
    run_op("sub_15_15",  4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0);
    run_op("sub_15_0",   4'd15, 4'd0,  1'b0, 4'd15, 1'b0, 1'b0);
    run_op("ignore_mid", 4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1);
    run_op("sub_5_11_b", 4'd5,  4'd11, 1'b1, 4'd9,  1'b1, 1'b0);

    // start held high: done every W+2 cycles
    @(negedge clk);
    start = 1'b1; a = 4'd8; b = 4'd1; bin = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40 && ndone < 3; i++) begin
      @(negedge clk);
      if (done) begin
        done_at[ndone] = i;
        check("b2b_diff", diff, 7);
        ndone++;
      end
    end
    start = 1'b0;
    check("b2b_count", ndone, 3);
    if (ndone == 3) begin
      check("b2b_gap0", done_at[1] - done_at[0], W + 2);
      check("b2b_gap1", done_at[2] - done_at[1], W + 2);
    end
    repeat (W + 3) @(negedge clk);
    check("b2b_idle", busy, 0);

    // reset on the second SHIFT cycle abandons the operation
    start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_bout", bout, 0);
    cyc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) cyc++;
    end
    check("mid_rst_no_done", cyc, 0);

    run_op("post_rst_12_5", 4'd12, 4'd5, 1'b0, 4'd7, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
